// File: rtl/iadc_pkg.sv
// rtl/iadc_pkg.sv - shared widths, averaging FSM states and helpers for the IADC sample buffer
package iadc_pkg;

    localparam int IADC_DATA_W  = 12;
    localparam int AVG_SEL_W    = 2;
    localparam int AVG_MAX_LOG2 = 3;
    localparam int ACC_W        = IADC_DATA_W + AVG_MAX_LOG2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } win_state_t;

    // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/iadc_sync_fifo.sv
// rtl/iadc_sync_fifo.sv - single-clock show-ahead FIFO; head word is presented combinationally, 0 when empty
module iadc_sync_fifo
    import iadc_pkg::*;
#(
    parameter int DATA_W = IADC_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        full    = (level == LVL_W'(DEPTH));
        empty   = (level == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/iadc_sample_buffer.sv
// rtl/iadc_sample_buffer.sv - new_data edge detect, 1/2/4/8 sample averaging and overflow-tracked FIFO buffering
module iadc_sample_buffer
    import iadc_pkg::*;
#(
    parameter int DATA_W = IADC_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [AVG_SEL_W-1:0]        avg_sel,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic [CNT_W-1:0]            drop_count
);

    localparam int SUM_W = DATA_W + AVG_MAX_LOG2;
    localparam int LEN_W = AVG_MAX_LOG2 + 1;

    win_state_t              state;
    logic                    in_prev;
    logic [SUM_W-1:0]        acc;
    logic [AVG_MAX_LOG2-1:0] win_cnt;
    logic [AVG_SEL_W-1:0]    win_sel;

    logic                    sample;
    logic [AVG_SEL_W-1:0]    cur_sel;
    logic [LEN_W-1:0]        win_len;
    logic [SUM_W-1:0]        sum;
    logic                    win_done;
    logic [DATA_W-1:0]       result;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;

    // The first sample of a window uses avg_sel directly; later samples use the latched size.
    always_comb begin
        sample   = in_valid & ~in_prev & enable;
        cur_sel  = (state == ST_IDLE) ? avg_sel : win_sel;
        win_len  = LEN_W'(1) << cur_sel;
        sum      = acc + SUM_W'(in_data);
        win_done = ({1'b0, win_cnt} == (win_len - 1'b1));
        result   = DATA_W'(sum >> cur_sel);
        push     = sample & win_done;
        pop      = rd_valid & rd_ready;
        drop     = push & fifo_full & ~pop;
    end

    assign rd_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            in_prev <= 1'b0;
            acc     <= '0;
            win_cnt <= '0;
            win_sel <= '0;
        end else begin
            in_prev <= in_valid;
            if (!enable) begin
                state   <= ST_IDLE;
                acc     <= '0;
                win_cnt <= '0;
            end else if (sample) begin
                if (state == ST_IDLE) win_sel <= avg_sel;
                if (win_done) begin
                    state   <= ST_IDLE;
                    acc     <= '0;
                    win_cnt <= '0;
                end else begin
                    state   <= ST_ACCUM;
                    acc     <= sum;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

    // A drop in the same cycle as a clear wins: the flag stays set and the count restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= CNT_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    iadc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_iadc_sample_buffer.sv
// tb/tb_iadc_sample_buffer.sv - directed and randomized bench for iadc_sample_buffer against a queue-based reference model
module tb_iadc_sample_buffer;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [1:0]        avg_sel;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              clr_overflow;
    logic [CNT_W-1:0]  drop_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    int q[$];
    bit m_prev;
    int m_cnt;
    int m_sum;
    int m_len;
    bit m_ovf;
    int m_drops;

    iadc_sample_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .avg_sel      (avg_sel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the rules to the inputs that were held across the clock edge just taken.
    task automatic model_update();
        int  res;
        bit  have;
        bit  pop;
        bit  drop;
        if (rst) begin
            q.delete();
            m_prev  = 0;
            m_cnt   = 0;
            m_sum   = 0;
            m_len   = 1;
            m_ovf   = 0;
            m_drops = 0;
            return;
        end
        have = 0;
        res  = 0;
        pop  = (q.size() > 0) && rd_ready;
        if (!enable) begin
            m_cnt = 0;
            m_sum = 0;
        end else if (in_valid && !m_prev) begin
            if (m_cnt == 0) m_len = 1 << avg_sel;
            m_sum += int'(in_data);
            m_cnt++;
            if (m_cnt == m_len) begin
                res   = m_sum / m_len;
                have  = 1;
                m_cnt = 0;
                m_sum = 0;
            end
        end
        drop = have && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (have && !drop) q.push_back(res);
        if (drop) begin
            m_ovf   = 1;
            m_drops = clr_overflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (clr_overflow) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        m_prev = in_valid;
    endtask

    task automatic compare_all();
        check("level", 32'(level), 32'(q.size()));
        check("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
        check("rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic pulse(input int d);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        rd_ready = 1'b0;
    endtask

    initial begin
        int five [5];
        five = '{12'h001, 12'h7FF, 12'hFFF, 12'h000, 12'h123};

        rst = 1'b1; enable = 1'b0; avg_sel = 2'd0; in_data = '0;
        in_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_level", 32'(level), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        // five single-sample entries, then read back in order
        enable = 1'b1;
        for (int i = 0; i < 5; i++) pulse(five[i]);
        check("five_level", 32'(level), 32'd5);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("five_order", 32'(rd_data), 32'(five[i]));
            step();
        end
        rd_ready = 1'b0;
        check("five_empty", 32'(rd_valid), 32'd0);

        // averaging of 8 and of 4
        avg_sel = 2'd3;
        for (int i = 0; i < 8; i++) pulse(12'hFFF);
        check("avg8_level", 32'(level), 32'd1);
        check("avg8_data", 32'(rd_data), 32'hFFF);
        drain();
        avg_sel = 2'd2;
        for (int i = 1; i <= 4; i++) pulse(i);
        check("avg4_data", 32'(rd_data), 32'h002);
        drain();

        // held-high new_data counts once per rising edge
        avg_sel = 2'd0;
        in_data = 12'h055;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("held_level", 32'(level), 32'd2);
        drain();

        // overflow with 11 samples, then clear
        for (int i = 0; i < 11; i++) pulse(12'h100 + i);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd3);
        check("ovf_head", 32'(rd_data), 32'h100);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_drops", 32'(drop_count), 32'd0);

        // full FIFO, push coincident with pop
        in_valid = 1'b1; in_data = 12'hABC; rd_ready = 1'b1;
        step();
        in_valid = 1'b0; rd_ready = 1'b0;
        step();
        check("fullpp_level", 32'(level), 32'd8);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        rd_ready = 1'b0;
        check("fullpp_last", 32'(rd_data), 32'hABC);
        drain();

        // partial window discarded by enable low
        avg_sel = 2'd2;
        pulse(12'h100);
        pulse(12'h100);
        enable = 1'b0;
        step();
        enable = 1'b1;
        check("discard_level", 32'(level), 32'd0);
        for (int i = 1; i <= 4; i++) pulse(4 * i);
        check("fresh_level", 32'(level), 32'd1);
        check("fresh_data", 32'(rd_data), 32'd10);
        drain();

        // reset with occupancy and a window in progress
        avg_sel = 2'd0;
        for (int i = 0; i < 5; i++) pulse(12'h200 + i);
        avg_sel = 2'd2;
        pulse(12'h300);
        pulse(12'h300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_data", 32'(rd_data), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        avg_sel = 2'd0;
        pulse(12'h0F0);
        check("rst_new_win", 32'(rd_data), 32'h0F0);
        drain();

        // drop counter saturation
        for (int i = 0; i < DEPTH + 260; i++) pulse(i);
        check("sat_drops", 32'(drop_count), 32'd255);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("sat_clr", 32'(drop_count), 32'd0);
        drain();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid     = ($urandom % 3) != 0;
            in_data      = DATA_W'($urandom);
            rd_ready     = (i < 2000) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
            enable       = ($urandom % 40) != 0;
            clr_overflow = ($urandom % 64) == 0;
            rst          = ($urandom % 600) == 0;
            if (($urandom % 50) == 0) avg_sel = 2'($urandom);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
